// File: rtl/branch_history_table.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Fetch lookup is combinational; execute-stage resolution trains the table and counts branches/misses.
module branch_history_table #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BranchE,
  input  logic [31:0] PCE,
  input  logic        TakenE,
  input  logic [31:0] TargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] BranchCount,
  output logic [31:0] MissCount
);

  localparam int ENTRIES = 1 << IDX_W;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];
  logic [31:0]      branch_cnt_q, branch_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  logic             unused_pce_bits;

  function automatic logic [1:0] ctr_sat(input logic [1:0] c, input logic up);
    logic [1:0] r;
    r = c;
    if (up && c != 2'b11)
      r = c + 2'b01;
    else if (!up && c != 2'b00)
      r = c - 2'b01;
    return r;
  endfunction

  function automatic logic [31:0] cnt_sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[IDX_W+TAG_W+1:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pce_bits = ^{PCE[1:0], PCE[31:IDX_W+TAG_W+2]};

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  // Fetch lookup sees registered contents only, so same-cycle updates appear next cycle.
  assign PredTakenF  = hit_f && ctr_q[idx_f][1];
  assign PredTargetF = PredTakenF ? target_q[idx_f] : PCF + 32'd4;

  assign MispredictE = BranchE && ((PredTakenE != TakenE) ||
                                   (TakenE && (PredTargetE != TargetE)));

  assign BranchCount = branch_cnt_q;
  assign MissCount   = miss_cnt_q;

  always_comb begin
    valid_d      = valid_q;
    tag_d        = tag_q;
    target_d     = target_q;
    ctr_d        = ctr_q;
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (BranchE) begin
      branch_cnt_d = cnt_sat_inc(branch_cnt_q);
      if (hit_e) begin
        ctr_d[idx_e] = ctr_sat(ctr_q[idx_e], TakenE);
        if (TakenE)
          target_d[idx_e] = TargetE;
      end else if (TakenE) begin
        // Taken miss evicts whatever alias occupies this slot.
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        target_d[idx_e] = TargetE;
        ctr_d[idx_e]    = 2'b10;
      end
    end
    if (MispredictE)
      miss_cnt_d = cnt_sat_inc(miss_cnt_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b00;
      end
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      target_q     <= target_d;
      ctr_q        <= ctr_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

endmodule
